lut_cfg_loader: RTL and testbench

- Configuration-side stage directly upstream of the fracturable dual-LUT cell.
- Accepts a configuration bitstream in WORD_W-bit beats over a valid/ready handshake.
- Assembles the full CFG_WIDTH-bit word: both LUT truth tables plus the fracture (split) bit in the MSB.
- Presents the assembled word on config_out and pulses cen for exactly one cclk cycle so the LUT captures it atomically.

---
 rtl/lut_cfg_loader.sv | 92 +++++++++
 tb/tb_lut_cfg_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader.sv
// Configuration loader for the fracturable dual-LUT cell.
// Collects WORD_W-bit beats LSB-first into a shift register, then publishes
// the complete CFG_WIDTH-bit word on config_out with a single-cycle cen pulse,
// so the LUT only ever captures whole configuration words.
module lut_cfg_loader #(
  parameter int INPUTS    = 4,
  parameter int MEM_SIZE  = 2**INPUTS,
  parameter int CFG_WIDTH = 2*MEM_SIZE+1,
  parameter int WORD_W    = 8,
  parameter int BEATS     = (CFG_WIDTH+WORD_W-1)/WORD_W
) (
  input  logic                         cclk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [WORD_W-1:0]            cfg_data,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic [CFG_WIDTH-1:0]         config_out,
  output logic                         cen,
  output logic                         busy,
  output logic                         loaded,
  output logic [$clog2(BEATS+1)-1:0]   beat_count
);

  localparam int SRW = BEATS*WORD_W;
  localparam int BCW = $clog2(BEATS+1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS-1);

  typedef enum logic {ST_LOAD, ST_COMMIT} state_t;

  state_t               r_state;
  logic [SRW-1:0]       r_sr;
  logic [BCW-1:0]       r_beat_count;
  logic [CFG_WIDTH-1:0] r_config_out;
  logic                 r_cen;
  logic                 r_loaded;

  logic                 w_accept;
  logic [SRW-1:0]       w_sr_next;

  // New beat enters at the top; the oldest WORD_W bits fall off the bottom.
  assign w_sr_next = SRW'({cfg_data, r_sr} >> WORD_W);
  assign cfg_ready = (r_state == ST_LOAD) && !cfg_start && !rst;
  assign w_accept  = cfg_valid && cfg_ready;

  // Loader FSM: shift beats in LOAD, publish the word and pulse cen in COMMIT.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_sr         <= '0;
      r_beat_count <= '0;
      r_config_out <= '0;
      r_cen        <= 1'b0;
      r_loaded     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (cfg_start) begin
            // Abort the partial word; the last committed word stays visible.
            r_sr         <= '0;
            r_beat_count <= '0;
          end else if (w_accept) begin
            r_sr <= w_sr_next;
            if (r_beat_count == LAST_BEAT) begin
              // Final beat: publish including this beat, padding bits dropped.
              r_config_out <= w_sr_next[CFG_WIDTH-1:0];
              r_beat_count <= '0;
              r_cen        <= 1'b1;
              r_state      <= ST_COMMIT;
            end else begin
              r_beat_count <= r_beat_count + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          // cfg_start is deliberately ignored here so the commit always lands.
          r_cen    <= 1'b0;
          r_loaded <= 1'b1;
          r_state  <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign config_out = r_config_out;
  assign cen        = r_cen;
  assign loaded     = r_loaded;
  assign beat_count = r_beat_count;
  assign busy       = (r_beat_count != '0) || (r_state == ST_COMMIT);

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader (INPUTS=4, WORD_W=8 -> 33-bit word, 5 beats).
// Expected words go into a scoreboard queue as stimulus is driven and are
// popped when cen fires; a small cycle model tracks beat count, cen, busy,
// loaded and the held config_out value.
module tb_lut_cfg_loader;

  localparam int CW = 33;
  localparam int BW = 3;

  logic          cclk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] config_out;
  logic          cen;
  logic          busy;
  logic          loaded;
  logic [BW-1:0] beat_count;

  lut_cfg_loader #(.INPUTS(4), .WORD_W(8)) dut (
    .cclk(cclk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .config_out(config_out),
    .cen(cen), .busy(busy), .loaded(loaded), .beat_count(beat_count)
  );

  always #5 cclk = ~cclk;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] sb_q[$];

  // Bench model state
  bit            armed = 0;
  int            acc   = 0;
  bit            fin   = 0;
  bit            lexp  = 0;
  logic [CW-1:0] cur_exp = '0;
  int            cyc   = 0;
  int            ncen  = 0;
  int            cen_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model update from the handshake as seen at the active edge.
  always @(posedge cclk) begin
    cyc++;
    if (rst) begin
      acc = 0; fin = 0; lexp = 0; cur_exp = '0;
    end else begin
      if (fin) lexp = 1;
      fin = 0;
      if (cfg_valid && cfg_ready) begin
        if (acc == 4) begin acc = 0; fin = 1; end
        else acc++;
      end else if (cfg_start) begin
        acc = 0;
      end
    end
  end

  // Output checks away from the active edge.
  always @(negedge cclk) begin
    if (armed) begin
      chk("cen", 64'(cen), 64'(fin));
      if (cen) begin
        ncen++;
        cen_cyc.push_back(cyc);
        chk("ready_in_commit", 64'(cfg_ready), 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_cen", 64'd1, 64'd0);
        end else begin
          cur_exp = sb_q.pop_front();
        end
      end
      chk("config_out", 64'(config_out), 64'(cur_exp));
      chk("beat_count", 64'(beat_count), 64'(acc));
      chk("busy", 64'(busy), 64'((acc != 0) || fin));
      chk("loaded", 64'(loaded), 64'(lexp));
    end
  end

  // Offer one beat (valid stays high afterwards) and wait for acceptance.
  task automatic beat(input logic [7:0] d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    #1;
    while (!cfg_ready && n < 20) begin
      @(negedge cclk); #1;
      n++;
    end
    if (n >= 20) chk("beat_timeout", 64'd1, 64'd0);
    @(posedge cclk);
    @(negedge cclk);
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) @(negedge cclk);
  endtask

  function automatic logic [CW-1:0] assemble(input logic [7:0] b0, b1, b2, b3, b4);
    logic [39:0] t;
    t = {b4, b3, b2, b1, b0};
    return t[CW-1:0];
  endfunction

  initial begin
    logic [7:0] w[5];
    int c0;
    rst = 1'b1; cfg_start = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    repeat (3) @(negedge cclk);
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_cen", 64'(cen), 64'd0);
    chk("rst_config_out", 64'(config_out), 64'd0);
    chk("rst_loaded", 64'(loaded), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    armed = 1;
    @(negedge cclk);

    // 1: back-to-back word
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    sb_q.push_back(33'h1_4433_2211);
    beat(8'h01);
    idle(3);
    chk("s1_ncen", 64'(ncen), 64'd1);
    chk("s1_loaded", 64'(loaded), 64'd1);

    // 2: padding bits of the final beat are dropped
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    sb_q.push_back(33'h1_4433_2211);
    beat(8'hFF);
    idle(3);
    chk("s2_ncen", 64'(ncen), 64'd2);

    // 3: cfg_start aborts a partial word and blocks the concurrent beat
    beat(8'h77); beat(8'h66);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hAA;
    #1;
    chk("s3_ready_on_start", 64'(cfg_ready), 64'd0);
    @(negedge cclk);
    cfg_start = 1'b0; cfg_valid = 1'b0;
    #1;
    chk("s3_beat_count", 64'(beat_count), 64'd0);
    chk("s3_held_out", 64'(config_out), 64'h1_4433_2211);
    @(negedge cclk);
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    sb_q.push_back(33'h1_0403_0201);
    beat(8'h05);
    idle(3);
    chk("s3_ncen", 64'(ncen), 64'd3);

    // 4: random gaps between beats
    idle($urandom_range(0, 3)); beat(8'h11);
    idle($urandom_range(0, 3)); beat(8'h22);
    idle($urandom_range(1, 3)); beat(8'h33);
    idle($urandom_range(0, 3)); beat(8'h44);
    sb_q.push_back(33'h1_4433_2211);
    idle($urandom_range(1, 3)); beat(8'h01);
    idle(3);
    chk("s4_ncen", 64'(ncen), 64'd4);

    // 5: reset mid-word, then a fresh word
    beat(8'hDE); beat(8'hAD); beat(8'hBE);
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge cclk);
    rst = 1'b0;
    #1;
    chk("s5_config_out", 64'(config_out), 64'd0);
    chk("s5_loaded", 64'(loaded), 64'd0);
    chk("s5_beat_count", 64'(beat_count), 64'd0);
    @(negedge cclk);
    beat(8'hA1); beat(8'hB2); beat(8'hC3); beat(8'hD4);
    sb_q.push_back(33'h0_D4C3_B2A1);
    beat(8'hE6);
    idle(3);
    chk("s5_ncen", 64'(ncen), 64'd5);

    // 6: two words back-to-back with valid held high
    c0 = cen_cyc.size();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) beat(w[i]);
      sb_q.push_back(assemble(w[0], w[1], w[2], w[3], w[4]));
      beat(w[4]);
    end
    idle(3);
    chk("s6_ncen", 64'(ncen), 64'd7);
    if (cen_cyc.size() >= c0 + 2)
      chk("s6_cen_spacing", 64'(cen_cyc[c0+1] - cen_cyc[c0]), 64'd6);
    else
      chk("s6_cen_missing", 64'(cen_cyc.size() - c0), 64'd2);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
